// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU operation scheduler:
// FSM states, unit selects and FUN field layout.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_t;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  typedef struct packed {
    logic [1:0] unit;
    logic [1:0] sub;
  } fun_t;

  // bit 0 arith, 1 logic, 2 cmp, 3 shift
  function automatic logic [3:0] unit_onehot(
    input logic [1:0] unit
  );
    logic [3:0] oh;
    oh = '0;
    unique case (unit)
      UNIT_ARITH: oh[0] = 1'b1;
      UNIT_LOGIC: oh[1] = 1'b1;
      UNIT_CMP:   oh[2] = 1'b1;
      UNIT_SHIFT: oh[3] = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-input round-robin arbiter; the pointer
// moves to the other requester on each accept.
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr_q;

  // a lone request wins outright; ties go to ptr
  always_comb begin
    gnt_id = 1'b0;
    unique case (req)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ptr_q;
      default: gnt_id = 1'b0;
    endcase
    gnt = '0;
    if (req != 2'b00) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

  // hand priority to the loser after a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= ~gnt_id;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares the ALU units between two requesters:
// arbitrate, pulse one enable, await flag, respond.
module alu_op_scheduler #(
  parameter int A_width     = 16,
  parameter int B_width     = 16,
  parameter int OUT_width   = 16,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                 CLK_SCH,
  input  logic                 RST_SCH,
  input  logic                 REQ0_VALID,
  input  logic [A_width-1:0]   REQ0_A,
  input  logic [B_width-1:0]   REQ0_B,
  input  logic [3:0]           REQ0_FUN,
  output logic                 REQ0_READY,
  input  logic                 REQ1_VALID,
  input  logic [A_width-1:0]   REQ1_A,
  input  logic [B_width-1:0]   REQ1_B,
  input  logic [3:0]           REQ1_FUN,
  output logic                 REQ1_READY,
  output logic [A_width-1:0]   A_OUT,
  output logic [B_width-1:0]   B_OUT,
  output logic [1:0]           ALU_FUN_OUT,
  output logic                 ARITH_EN,
  output logic                 LOGIC_EN,
  output logic                 CMP_EN,
  output logic                 SHIFT_EN,
  input  logic [OUT_width-1:0] ALU_RESULT,
  input  logic                 ALU_FLAG,
  output logic                 RESP_VALID,
  input  logic                 RESP_READY,
  output logic                 RESP_ID,
  output logic [OUT_width-1:0] RESP_DATA,
  output logic                 RESP_ERR
);

  import alu_sched_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  sched_state_t state_q;
  sched_state_t state_d;

  logic [1:0]         req;
  logic [1:0]         gnt;
  logic               gnt_id;
  logic               idle;
  logic               hs;
  logic               timeout;
  logic [A_width-1:0] sel_a;
  logic [B_width-1:0] sel_b;
  fun_t               sel_fun;
  logic [3:0]         en_q;
  logic               id_q;
  logic [CNT_W-1:0]   cnt_q;

  assign req  = {REQ1_VALID, REQ0_VALID};
  assign idle = (state_q == S_IDLE);
  assign hs   = idle & (|gnt);

  assign REQ0_READY = RST_SCH & idle & gnt[0];
  assign REQ1_READY = RST_SCH & idle & gnt[1];

  assign sel_a   = gnt_id ? REQ1_A : REQ0_A;
  assign sel_b   = gnt_id ? REQ1_B : REQ0_B;
  assign sel_fun = gnt_id ? fun_t'(REQ1_FUN)
                          : fun_t'(REQ0_FUN);

  assign timeout = (cnt_q == CNT_LAST);

  assign ARITH_EN = en_q[0];
  assign LOGIC_EN = en_q[1];
  assign CMP_EN   = en_q[2];
  assign SHIFT_EN = en_q[3];

  alu_rr_arb2 u_arb (
    .clk    (CLK_SCH),
    .rst_n  (RST_SCH),
    .req    (req),
    .accept (hs),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // state register
  always_ff @(posedge CLK_SCH or negedge RST_SCH) begin
    if (!RST_SCH) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state; a flag in the timeout cycle still ends WAIT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hs) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (ALU_FLAG || timeout) state_d = S_RESP;
      end
      S_RESP:  if (RESP_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // operand latch, enable pulse, timeout and response
  always_ff @(posedge CLK_SCH or negedge RST_SCH) begin
    if (!RST_SCH) begin
      A_OUT       <= '0;
      B_OUT       <= '0;
      ALU_FUN_OUT <= '0;
      en_q        <= '0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      RESP_VALID  <= 1'b0;
      RESP_ID     <= 1'b0;
      RESP_DATA   <= '0;
      RESP_ERR    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (hs) begin
            A_OUT       <= sel_a;
            B_OUT       <= sel_b;
            ALU_FUN_OUT <= sel_fun.sub;
            en_q        <= unit_onehot(sel_fun.unit);
            id_q        <= gnt_id;
          end
        end
        S_ISSUE: begin
          en_q  <= '0;
          cnt_q <= '0;
        end
        S_WAIT: begin
          if (ALU_FLAG) begin
            RESP_VALID <= 1'b1;
            RESP_ID    <= id_q;
            RESP_DATA  <= ALU_RESULT;
            RESP_ERR   <= 1'b0;
          end else if (timeout) begin
            RESP_VALID <= 1'b1;
            RESP_ID    <= id_q;
            RESP_DATA  <= '0;
            RESP_ERR   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (RESP_READY) RESP_VALID <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with a
// tiny flag/latency model standing in for the ALU.
module tb_alu_op_scheduler;

  logic        CLK_SCH;
  logic        RST_SCH;
  logic        REQ0_VALID;
  logic [15:0] REQ0_A;
  logic [15:0] REQ0_B;
  logic [3:0]  REQ0_FUN;
  logic        REQ0_READY;
  logic        REQ1_VALID;
  logic [15:0] REQ1_A;
  logic [15:0] REQ1_B;
  logic [3:0]  REQ1_FUN;
  logic        REQ1_READY;
  logic [15:0] A_OUT;
  logic [15:0] B_OUT;
  logic [1:0]  ALU_FUN_OUT;
  logic        ARITH_EN;
  logic        LOGIC_EN;
  logic        CMP_EN;
  logic        SHIFT_EN;
  logic [15:0] ALU_RESULT;
  logic        ALU_FLAG;
  logic        RESP_VALID;
  logic        RESP_READY;
  logic        RESP_ID;
  logic [15:0] RESP_DATA;
  logic        RESP_ERR;

  int          n_chk;
  int          n_fail;
  int          alu_lat;
  logic [15:0] alu_res;
  logic        en_any;

  assign en_any = ARITH_EN | LOGIC_EN | CMP_EN | SHIFT_EN;

  alu_op_scheduler #(
    .A_width     (16),
    .B_width     (16),
    .OUT_width   (16),
    .TIMEOUT_CYC (8)
  ) dut (
    .CLK_SCH     (CLK_SCH),
    .RST_SCH     (RST_SCH),
    .REQ0_VALID  (REQ0_VALID),
    .REQ0_A      (REQ0_A),
    .REQ0_B      (REQ0_B),
    .REQ0_FUN    (REQ0_FUN),
    .REQ0_READY  (REQ0_READY),
    .REQ1_VALID  (REQ1_VALID),
    .REQ1_A      (REQ1_A),
    .REQ1_B      (REQ1_B),
    .REQ1_FUN    (REQ1_FUN),
    .REQ1_READY  (REQ1_READY),
    .A_OUT       (A_OUT),
    .B_OUT       (B_OUT),
    .ALU_FUN_OUT (ALU_FUN_OUT),
    .ARITH_EN    (ARITH_EN),
    .LOGIC_EN    (LOGIC_EN),
    .CMP_EN      (CMP_EN),
    .SHIFT_EN    (SHIFT_EN),
    .ALU_RESULT  (ALU_RESULT),
    .ALU_FLAG    (ALU_FLAG),
    .RESP_VALID  (RESP_VALID),
    .RESP_READY  (RESP_READY),
    .RESP_ID     (RESP_ID),
    .RESP_DATA   (RESP_DATA),
    .RESP_ERR    (RESP_ERR)
  );

  initial CLK_SCH = 1'b0;
  always #5 CLK_SCH = ~CLK_SCH;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // unit model: enable seen in ISSUE, flag raised
  // alu_lat WAIT cycles later for one cycle
  initial begin
    ALU_FLAG   = 1'b0;
    ALU_RESULT = '0;
    forever begin
      @(negedge CLK_SCH);
      if (en_any && alu_lat >= 0) begin
        repeat (alu_lat + 1) @(negedge CLK_SCH);
        ALU_FLAG   = 1'b1;
        ALU_RESULT = alu_res;
        @(negedge CLK_SCH);
        ALU_FLAG   = 1'b0;
        ALU_RESULT = '0;
      end
    end
  end

  // one full transaction; starts and ends at an
  // IDLE negedge; lat counts cycles from ISSUE
  task automatic do_op(
    input string       tag,
    input logic [1:0]  vld,
    input logic        exp_id,
    input int          lat,
    input logic [15:0] res,
    input logic [3:0]  exp_en,
    input logic [15:0] exp_a,
    input logic [1:0]  exp_sub,
    input int          exp_lat,
    input logic        exp_err,
    input logic [15:0] exp_data,
    input int          hold
  );
    int   n;
    logic extra;
    alu_lat    = lat;
    alu_res    = res;
    REQ0_VALID = vld[0];
    REQ1_VALID = vld[1];
    #1;
    chk({tag, ".gnt"}, {REQ1_READY, REQ0_READY},
        exp_id ? 2'b10 : 2'b01);
    @(negedge CLK_SCH);
    if (exp_id) REQ1_VALID = 1'b0;
    else        REQ0_VALID = 1'b0;
    if (hold > 0) RESP_READY = 1'b0;
    #1;
    chk({tag, ".en"},
        {SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN}, exp_en);
    chk({tag, ".ops"}, {A_OUT, ALU_FUN_OUT},
        {exp_a, exp_sub});
    chk({tag, ".rdy_iss"},
        {REQ1_READY, REQ0_READY}, 2'b00);
    n     = 0;
    extra = 1'b0;
    while (!RESP_VALID && n < 40) begin
      @(negedge CLK_SCH);
      n++;
      if (en_any) extra = 1'b1;
    end
    chk({tag, ".lat"}, n, exp_lat);
    chk({tag, ".en_once"}, extra, 1'b0);
    chk({tag, ".resp"},
        {RESP_ID, RESP_ERR, RESP_DATA},
        {exp_id, exp_err, exp_data});
    repeat (hold) begin
      @(negedge CLK_SCH);
      chk({tag, ".hold"},
          {RESP_VALID, RESP_ID, RESP_DATA,
           REQ1_READY, REQ0_READY},
          {1'b1, exp_id, exp_data, 2'b00});
    end
    RESP_READY = 1'b1;
    @(negedge CLK_SCH);
    chk({tag, ".idle"}, RESP_VALID, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: no summary by time limit");
    $fatal(1);
  end

  initial begin
    int seen;
    n_chk      = 0;
    n_fail     = 0;
    alu_lat    = -1;
    alu_res    = '0;
    RST_SCH    = 1'b0;
    RESP_READY = 1'b1;
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    REQ0_A     = 16'h0003;
    REQ0_B     = 16'h0004;
    REQ0_FUN   = 4'b0000;
    REQ1_A     = 16'h0007;
    REQ1_B     = 16'h0009;
    REQ1_FUN   = 4'b1010;
    #3;
    chk("rst.rdy", {REQ1_READY, REQ0_READY}, 2'b00);
    chk("rst.out",
        {A_OUT, B_OUT, ALU_FUN_OUT, en_any,
         RESP_VALID, RESP_ID, RESP_DATA, RESP_ERR},
        '0);
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    @(negedge CLK_SCH);
    RST_SCH = 1'b1;
    @(negedge CLK_SCH);

    // both valid from reset: REQ0, REQ1, then REQ0
    do_op("dual0", 2'b11, 1'b0, 0, 16'h1234,
          4'b0001, 16'h0003, 2'b00,
          2, 1'b0, 16'h1234, 0);
    do_op("dual1", 2'b11, 1'b1, 0, 16'h0042,
          4'b0100, 16'h0007, 2'b10,
          2, 1'b0, 16'h0042, 0);
    // alternation plus 5 cycles of backpressure
    do_op("alt", 2'b11, 1'b0, 0, 16'h5A5A,
          4'b0001, 16'h0003, 2'b00,
          2, 1'b0, 16'h5A5A, 5);

    // compare equal, REQ0 alone with PTR at 1
    REQ0_A   = 16'h0005;
    REQ0_B   = 16'h0005;
    REQ0_FUN = 4'b1001;
    do_op("cmp", 2'b01, 1'b0, 0, 16'h0001,
          4'b0100, 16'h0005, 2'b01,
          2, 1'b0, 16'h0001, 0);

    // no flag: error after T WAIT cycles
    REQ1_A   = 16'h0F0F;
    REQ1_B   = 16'h0004;
    REQ1_FUN = 4'b1100;
    do_op("tmo", 2'b10, 1'b1, -1, 16'h0000,
          4'b1000, 16'h0F0F, 2'b00,
          9, 1'b1, 16'h0000, 0);

    // flag in the last WAIT cycle beats timeout
    REQ0_A   = 16'hFF00;
    REQ0_B   = 16'h00FF;
    REQ0_FUN = 4'b0110;
    do_op("late", 2'b01, 1'b0, 7, 16'h00A5,
          4'b0010, 16'hFF00, 2'b10,
          9, 1'b0, 16'h00A5, 0);

    // reset while in WAIT, with PTR at 1
    alu_lat    = -1;
    REQ0_VALID = 1'b1;
    #1;
    chk("mid.gnt", {REQ1_READY, REQ0_READY}, 2'b01);
    @(negedge CLK_SCH);
    REQ0_VALID = 1'b0;
    @(negedge CLK_SCH);
    #2;
    RST_SCH    = 1'b0;
    #1;
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    #1;
    chk("mid.rst",
        {A_OUT, B_OUT, ALU_FUN_OUT, en_any,
         RESP_VALID, RESP_ID, RESP_DATA, RESP_ERR,
         REQ1_READY, REQ0_READY},
        '0);
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    @(negedge CLK_SCH);
    RST_SCH = 1'b1;
    seen    = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK_SCH);
      if (RESP_VALID) seen++;
    end
    chk("mid.noresp", seen, 0);
    do_op("mid.dual", 2'b11, 1'b0, 0, 16'h0077,
          4'b0010, 16'hFF00, 2'b10,
          2, 1'b0, 16'h0077, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
